pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage MIPS pipeline. It drives PC write-enable, the IF/ID register enable, the IF flush and the ID-to-EX bubble insert. It also selects the next-PC source and tracks the multi-cycle multiply/divide unit (MDU). It sits beside the IF and ID stages, takes decoded ID fields and the EX load indication, and owns every stall and flush decision in the core.

---
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, flushes,
// next-PC select and multiply/divide unit tracking.
module pipeline_ctrl #(
  parameter int MDU_LAT      = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_mdu_start,
  input  logic             id_mdu_read,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  output logic             pc_write,
  output logic             if_write,
  output logic             if_flush,
  output logic             id_flush,
  output logic [1:0]       pc_src,
  output logic             mdu_go,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {S_FLUSH, S_RUN, S_MDU} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu, mh, stall;

  always_comb begin
    lu    = ex_memread && (ex_rt != 5'd0) &&
            ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mh    = (state_q == S_MDU) && (id_mdu_read || id_mdu_start);
    stall = lu || mh;

    pc_write    = 1'b0;
    if_write    = 1'b0;
    if_flush    = 1'b1;
    id_flush    = 1'b1;
    pc_src      = 2'b00;
    mdu_go      = 1'b0;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    mdu_cnt_d   = mdu_cnt_q;
    done_d      = 1'b0;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q == '0) state_d = S_RUN;
      end
      S_RUN, S_MDU: begin
        if (stall) begin
          if_flush = 1'b0;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
          pc_write = 1'b1;
          if_write = 1'b1;
          id_flush = 1'b0;
          if (jump) begin
            pc_src = 2'b10;
          end else if (branch_taken) begin
            pc_src = 2'b01;
          end else begin
            if_flush = 1'b0;
          end
          // A start can only be accepted in RUN; in MDU_BUSY it is a hazard.
          if ((state_q == S_RUN) && id_mdu_start) begin
            mdu_go    = 1'b1;
            state_d   = S_MDU;
            mdu_cnt_d = MW'(MDU_LAT - 1);
          end
        end
        if (state_q == S_MDU) begin
          mdu_cnt_d = mdu_cnt_q - 1'b1;
          // Registered done lands in the last busy cycle (counter == 0).
          if (mdu_cnt_q == MW'(1)) done_d = 1'b1;
          if (mdu_cnt_q == '0) state_d = S_RUN;
        end
      end
      default: state_d = S_FLUSH;
    endcase

    busy_d = (state_d == S_MDU);

    if (reset) begin
      pc_write = 1'b0;
      if_write = 1'b0;
      if_flush = 1'b1;
      id_flush = 1'b1;
      pc_src   = 2'b00;
      mdu_go   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FLUSH;
      flush_cnt_q <= FW'(FLUSH_CYCLES - 1);
      mdu_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mdu_cnt_q   <= mdu_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mdu_busy  = busy_q;
  assign mdu_done  = done_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second instance with CNT_W=4 covers
// stall counter saturation.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_mdu_start, id_mdu_read, branch_taken, jump, ex_memread;
  logic        pc_write, if_write, if_flush, id_flush, mdu_go, mdu_busy, mdu_done;
  logic [1:0]  pc_src;
  logic [15:0] stall_cnt;
  logic        s_pc_write, s_if_write, s_if_flush, s_id_flush, s_mdu_go, s_mdu_busy, s_mdu_done;
  logic [1:0]  s_pc_src;
  logic [3:0]  s_stall_cnt;
  logic [6:0]  ctrl;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;

  localparam logic [6:0] C_RESET  = 7'b0011000;
  localparam logic [6:0] C_RUN    = 7'b1100000;
  localparam logic [6:0] C_STALL  = 7'b0001000;
  localparam logic [6:0] C_BRANCH = 7'b1110010;
  localparam logic [6:0] C_JUMP   = 7'b1110100;
  localparam logic [6:0] C_MDUGO  = 7'b1100001;

  always #5 clk = ~clk;

  // {pc_write, if_write, if_flush, id_flush, pc_src, mdu_go}
  assign ctrl = {pc_write, if_write, if_flush, id_flush, pc_src, mdu_go};

  pipeline_ctrl #(.MDU_LAT(8), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read), .branch_taken(branch_taken),
    .jump(jump), .ex_memread(ex_memread), .ex_rt(ex_rt), .pc_write(pc_write),
    .if_write(if_write), .if_flush(if_flush), .id_flush(id_flush), .pc_src(pc_src),
    .mdu_go(mdu_go), .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.MDU_LAT(8), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read), .branch_taken(branch_taken),
    .jump(jump), .ex_memread(ex_memread), .ex_rt(ex_rt), .pc_write(s_pc_write),
    .if_write(s_if_write), .if_flush(s_if_flush), .id_flush(s_id_flush), .pc_src(s_pc_src),
    .mdu_go(s_mdu_go), .mdu_busy(s_mdu_busy), .mdu_done(s_mdu_done), .stall_cnt(s_stall_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_mdu_start = 1'b0; id_mdu_read = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; ex_memread = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) cyc();
    n_checks++;
    if (ctrl !== C_RESET) begin n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RESET); end
    n_checks++;
    if ({mdu_busy, mdu_done, stall_cnt} !== 18'd0) begin
      n_fail++; $display("FAIL reset_status: busy=%b done=%b cnt=%0d expected zeros", mdu_busy, mdu_done, stall_cnt);
    end
    reset = 1'b0;
    // Two FLUSH cycles after deassert; inputs must be ignored there.
    for (int k = 1; k <= 2; k++) begin
      jump = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== C_RESET) begin n_fail++; $display("FAIL flush_cycle%0d: got %b expected %b", k, ctrl, C_RESET); end
      cyc();
    end
    jump = 1'b0;
    #1;
    n_checks++;
    if (ctrl !== C_RUN) begin n_fail++; $display("FAIL first_run: got %b expected %b", ctrl, C_RUN); end
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    n_checks++;
    if (ctrl !== C_STALL) begin n_fail++; $display("FAIL lu_rs: got %b expected %b", ctrl, C_STALL); end
    cyc(); exp_stall++;
    n_checks++;
    if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL lu_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    n_checks++;
    if (ctrl !== C_RUN) begin n_fail++; $display("FAIL lu_r0: got %b expected %b", ctrl, C_RUN); end
    cyc();
    ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
    #1;
    n_checks++;
    if (ctrl !== C_RUN) begin n_fail++; $display("FAIL lu_rt_unused: got %b expected %b", ctrl, C_RUN); end
    id_uses_rt = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== C_STALL) begin n_fail++; $display("FAIL lu_rt: got %b expected %b", ctrl, C_STALL); end
    cyc(); exp_stall++;
    n_checks++;
    if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL lu_rt_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    clear_inputs();
  endtask

  task automatic test_branch_jump();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1; jump = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== C_STALL) begin n_fail++; $display("FAIL lu_over_branch: got %b expected %b", ctrl, C_STALL); end
    cyc(); exp_stall++;
    ex_memread = 1'b0; jump = 1'b0;
    #1;
    n_checks++;
    if (ctrl !== C_BRANCH) begin n_fail++; $display("FAIL branch: got %b expected %b", ctrl, C_BRANCH); end
    jump = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== C_JUMP) begin n_fail++; $display("FAIL jump_over_branch: got %b expected %b", ctrl, C_JUMP); end
    cyc();
    n_checks++;
    if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL branch_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    clear_inputs();
  endtask

  task automatic test_mdu();
    logic [6:0] exp_c;
    id_mdu_start = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== C_MDUGO) begin n_fail++; $display("FAIL mdu_go: got %b expected %b", ctrl, C_MDUGO); end
    cyc();
    for (int k = 1; k <= 8; k++) begin
      id_mdu_start = 1'b0;
      jump = (k == 2);
      id_mdu_read = (k >= 3);
      #1;
      exp_c = (k >= 3) ? C_STALL : ((k == 2) ? C_JUMP : C_RUN);
      n_checks++;
      if (ctrl !== exp_c) begin n_fail++; $display("FAIL mdu_ctrl_c%0d: got %b expected %b", k, ctrl, exp_c); end
      n_checks++;
      if ({mdu_busy, mdu_done} !== {1'b1, k == 8}) begin
        n_fail++; $display("FAIL mdu_status_c%0d: busy=%b done=%b expected busy=1 done=%0d", k, mdu_busy, mdu_done, k == 8);
      end
      if (k >= 3) exp_stall++;
      cyc();
    end
    #1;
    n_checks++;
    if ({mdu_busy, mdu_done} !== 2'b00) begin n_fail++; $display("FAIL mdu_end: busy=%b done=%b expected 0 0", mdu_busy, mdu_done); end
    n_checks++;
    if (ctrl !== C_RUN) begin n_fail++; $display("FAIL mdu_read_run: got %b expected %b", ctrl, C_RUN); end
    n_checks++;
    if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL mdu_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    clear_inputs();
    cyc();
  endtask

  task automatic test_reset_mid_mdu();
    id_mdu_start = 1'b1;
    cyc();
    id_mdu_start = 1'b0;
    ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== C_RESET) begin n_fail++; $display("FAIL mid_reset_ctrl: got %b expected %b", ctrl, C_RESET); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++;
      if ({mdu_busy, mdu_done, stall_cnt} !== 18'd0) begin
        n_fail++; $display("FAIL mid_reset_status%0d: busy=%b done=%b cnt=%0d expected zeros", k, mdu_busy, mdu_done, stall_cnt);
      end
    end
    reset = 1'b0;
    cyc();
    #1;
    n_checks++;
    if (ctrl !== C_RESET) begin n_fail++; $display("FAIL mid_reset_flush: got %b expected %b", ctrl, C_RESET); end
    cyc();
    ex_memread = 1'b0;
    exp_stall = 0;
  endtask

  task automatic test_saturation();
    int exp4;
    ex_memread = 1'b1; ex_rt = 5'd12; id_rs = 5'd12;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      exp_stall++;
      exp4 = (k > 15) ? 15 : k;
      n_checks++;
      if (s_stall_cnt !== 4'(exp4)) begin n_fail++; $display("FAIL sat_cnt%0d: got %0d expected %0d", k, s_stall_cnt, exp4); end
    end
    n_checks++;
    if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL wide_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    clear_inputs();
    cyc();
    n_checks++;
    if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", s_stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_mdu();
    test_reset_mid_mdu();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
